inv_key_schedule: RTL

Byte-serial AES-128 decryption key scheduler. It accepts the cipher key and runs the forward schedule internally to reach the round-10 key. It then emits round keys 10, 9, …, 0 in descending order over a valid/ready handshake, recomputing each previous key with the inverse recurrence. It feeds the InvAddRoundKey stage of the decryption datapath and reuses one SubBytes instance, one byte per cycle.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/sub_bytes.sv | 44 ++++
 rtl/inv_key_schedule.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: widths, round constants,
// RotWord and the state encoding of the decryption key scheduler.
package aes_pkg;

   localparam int WORD_W = 32;
   localparam int KEY_W  = 128;

   // rc[1] .. rc[10], rc[1] in the most significant byte
   localparam logic [79:0] RC_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FWD_SUB = 3'd1;
   localparam logic [2:0] ST_FWD_MIX = 3'd2;
   localparam logic [2:0] ST_OUT     = 3'd3;
   localparam logic [2:0] ST_INV_XOR = 3'd4;
   localparam logic [2:0] ST_INV_SUB = 3'd5;
   localparam logic [2:0] ST_INV_FIN = 3'd6;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      FWD_SUB = ST_FWD_SUB,
      FWD_MIX = ST_FWD_MIX,
      OUT     = ST_OUT,
      INV_XOR = ST_INV_XOR,
      INV_SUB = ST_INV_SUB,
      INV_FIN = ST_INV_FIN
   } state_t;

   function automatic logic [WORD_W-1:0] ROTWORD(input logic [WORD_W-1:0] x);
      return {x[23:0], x[31:24]};
   endfunction

   // Round constant word for r = 1..10; any other index yields zero
   function automatic logic [WORD_W-1:0] RCON(input logic [3:0] r);
      logic [7:0] rc;
      rc = 8'h00;
      if (r >= 4'd1 && r <= 4'd10) begin
         rc = RC_TABLE[8*(10 - int'(r)) +: 8];
      end
      return {rc, 24'h000000};
   endfunction

endpackage

// File: rtl/sub_bytes.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational, one byte in, one byte out.
module sub_bytes (
   input  logic [7:0] byte_in,
   output logic [7:0] byte_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the inverse for x != 0 and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] res;
      logic [7:0] base;
      logic [7:0] e;
      res  = 8'h01;
      base = x;
      e    = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) res = gf_mul(res, base);
         base = gf_mul(base, base);
      end
      return res;
   endfunction

   logic [7:0] inv;

   // Inverse then affine map with constant 0x63
   always_comb begin
      inv    = gf_inv(byte_in);
      byte_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/inv_key_schedule.sv
// Byte-serial AES-128 decryption key scheduler: expands the cipher key
// forward to round 10, then emits round keys 10..0 over valid/ready,
// stepping backwards with the inverse recurrence. One shared S-box.
module inv_key_schedule
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KEY_W-1:0]  key_in,
   output logic              busy,
   output logic              key_valid,
   input  logic              key_ready,
   output logic [KEY_W-1:0]  round_key_o,
   output logic [3:0]        key_round
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   genvar gi;

   state_t            state_reg;
   logic [WORD_W-1:0] w_reg [4];
   logic [1:0]        cnt_reg;
   logic [3:0]        rnd_reg;
   logic [7:0]        g_reg [4];

   logic [WORD_W-1:0] rot_w3;
   logic [7:0]        rot_bytes [4];
   logic [7:0]        sb_in;
   logic [7:0]        sb_out;
   logic [WORD_W-1:0] g_word;

   logic [WORD_W-1:0] mix_w0, mix_w1, mix_w2, mix_w3;
   logic [WORD_W-1:0] back_w1, back_w2, back_w3;
   logic [WORD_W-1:0] fin_w0;

   // Byte k of RotWord(w3); w3 always holds the word that feeds SubWord,
   // in the forward phase and after INV_XOR in the inverse phase alike
   assign rot_w3 = ROTWORD(w_reg[3]);
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot_bytes
         assign rot_bytes[gi] = rot_w3[WORD_W-1-8*gi -: 8];
      end
   endgenerate

   assign sb_in  = rot_bytes[cnt_reg];
   assign g_word = {g_reg[0], g_reg[1], g_reg[2], g_reg[3]};

   sub_bytes u_sbox (
      .byte_in (sb_in),
      .byte_o  (sb_out)
   );

   // Forward step, inverse XOR chain and inverse w0 recovery
   always_comb begin
      mix_w0  = w_reg[0] ^ g_word ^ RCON(rnd_reg);
      mix_w1  = w_reg[1] ^ mix_w0;
      mix_w2  = w_reg[2] ^ mix_w1;
      mix_w3  = w_reg[3] ^ mix_w2;
      back_w1 = w_reg[1] ^ w_reg[0];
      back_w2 = w_reg[2] ^ w_reg[1];
      back_w3 = w_reg[3] ^ w_reg[2];
      fin_w0  = w_reg[0] ^ g_word ^ RCON(key_round);
   end

   // Control FSM and datapath registers; all outputs are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         for (int i = 0; i < 4; i++) begin
            w_reg[i] <= '0;
            g_reg[i] <= '0;
         end
         cnt_reg     <= '0;
         rnd_reg     <= '0;
         busy        <= 1'b0;
         key_valid   <= 1'b0;
         round_key_o <= '0;
         key_round   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  w_reg[0]  <= key_in[127:96];
                  w_reg[1]  <= key_in[95:64];
                  w_reg[2]  <= key_in[63:32];
                  w_reg[3]  <= key_in[31:0];
                  rnd_reg   <= 4'd1;
                  cnt_reg   <= 2'd0;
                  busy      <= 1'b1;
                  state_reg <= FWD_SUB;
               end
            end
            FWD_SUB: begin
               g_reg[cnt_reg] <= sb_out;
               cnt_reg        <= cnt_reg + 2'd1;
               if (cnt_reg == 2'd3) state_reg <= FWD_MIX;
            end
            FWD_MIX: begin
               w_reg[0]    <= mix_w0;
               w_reg[1]    <= mix_w1;
               w_reg[2]    <= mix_w2;
               w_reg[3]    <= mix_w3;
               round_key_o <= {mix_w0, mix_w1, mix_w2, mix_w3};
               if (rnd_reg == LAST_RND) begin
                  key_round <= LAST_RND;
                  key_valid <= 1'b1;
                  state_reg <= OUT;
               end else begin
                  rnd_reg   <= rnd_reg + 4'd1;
                  state_reg <= FWD_SUB;
               end
            end
            OUT: begin
               if (key_valid && key_ready) begin
                  key_valid <= 1'b0;
                  if (key_round == 4'd0) begin
                     busy      <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     state_reg <= INV_XOR;
                  end
               end
            end
            INV_XOR: begin
               w_reg[1]    <= back_w1;
               w_reg[2]    <= back_w2;
               w_reg[3]    <= back_w3;
               round_key_o <= {w_reg[0], back_w1, back_w2, back_w3};
               state_reg   <= INV_SUB;
            end
            INV_SUB: begin
               g_reg[cnt_reg] <= sb_out;
               cnt_reg        <= cnt_reg + 2'd1;
               if (cnt_reg == 2'd3) state_reg <= INV_FIN;
            end
            INV_FIN: begin
               w_reg[0]    <= fin_w0;
               round_key_o <= {fin_w0, w_reg[1], w_reg[2], w_reg[3]};
               key_round   <= key_round - 4'd1;
               key_valid   <= 1'b1;
               state_reg   <= OUT;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
